// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Mode/field-select controller for the clock/calendar front panel. Button
// strobes move it between normal display, a setup menu and three field-edit
// modes. While a field is being edited, its blink enable alternates with each
// blink_tick event so the display driver can blank that digit pair.
//
// Ports:
//   clk                 in   system clock, rising edge
//   rst                 in   asynchronous reset, active-low
//   display             in   mode button, active-high (press = 0->1)
//   blink_tick          in   blink timebase, each 0->1 is one blink event
//   setup_second_day    in   seconds/day select button, active-low (press = 1->0)
//   setup_minute_month  in   minutes/month select button, active-low
//   setup_hour_year     in   hours/year select button, active-low
//   blink_sec_day       out  1 = blank seconds/day field in this blink phase
//   blink_min_month     out  1 = blank minutes/month field
//   blink_hour_year     out  1 = blank hours/year field
// -----------------------------------------------------------------------------
module control_unit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic display,
  input  logic blink_tick,
  input  logic setup_second_day,
  input  logic setup_minute_month,
  input  logic setup_hour_year,
  output logic blink_sec_day,
  output logic blink_min_month,
  output logic blink_hour_year
);

  // A single flop is not a synchronizer; clamp to two stages.
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    ST_DISPLAY = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SEC     = 3'd2,
    ST_MIN     = 3'd3,
    ST_HOUR    = 3'd4
  } state_t;

  logic [SS-1:0] disp_sync_q;
  logic [SS-1:0] tick_sync_q;
  logic [SS-1:0] sec_sync_q;
  logic [SS-1:0] min_sync_q;
  logic [SS-1:0] hour_sync_q;

  logic disp_prev_q;
  logic tick_prev_q;
  logic sec_prev_q;
  logic min_prev_q;
  logic hour_prev_q;

  logic disp_pulse;
  logic tick_pulse;
  logic sec_pulse;
  logic min_pulse;
  logic hour_pulse;

  state_t state_q, state_d;
  logic   phase_q, phase_d;
  logic   enter_field;

  // Synchronizers and edge flops. Reset values equal the idle level of each
  // input so that releasing reset with buttons idle never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_sync_q <= '0;
      tick_sync_q <= '0;
      sec_sync_q  <= '1;
      min_sync_q  <= '1;
      hour_sync_q <= '1;
      disp_prev_q <= 1'b0;
      tick_prev_q <= 1'b0;
      sec_prev_q  <= 1'b1;
      min_prev_q  <= 1'b1;
      hour_prev_q <= 1'b1;
    end else begin
      disp_sync_q <= {disp_sync_q[SS-2:0], display};
      tick_sync_q <= {tick_sync_q[SS-2:0], blink_tick};
      sec_sync_q  <= {sec_sync_q[SS-2:0],  setup_second_day};
      min_sync_q  <= {min_sync_q[SS-2:0],  setup_minute_month};
      hour_sync_q <= {hour_sync_q[SS-2:0], setup_hour_year};
      disp_prev_q <= disp_sync_q[SS-1];
      tick_prev_q <= tick_sync_q[SS-1];
      sec_prev_q  <= sec_sync_q[SS-1];
      min_prev_q  <= min_sync_q[SS-1];
      hour_prev_q <= hour_sync_q[SS-1];
    end
  end

  // Rising edge for active-high inputs, falling edge for active-low buttons.
  assign disp_pulse = disp_sync_q[SS-1] & ~disp_prev_q;
  assign tick_pulse = tick_sync_q[SS-1] & ~tick_prev_q;
  assign sec_pulse  = ~sec_sync_q[SS-1]  & sec_prev_q;
  assign min_pulse  = ~min_sync_q[SS-1]  & min_prev_q;
  assign hour_pulse = ~hour_sync_q[SS-1] & hour_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_DISPLAY;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    enter_field = 1'b0;

    case (state_q)
      ST_DISPLAY: begin
        if (disp_pulse) state_d = ST_SETUP;
      end
      ST_SETUP, ST_SEC, ST_MIN, ST_HOUR: begin
        // display outranks the field buttons; among fields sec > min > hour.
        if (disp_pulse) begin
          state_d = ST_DISPLAY;
        end else if (sec_pulse) begin
          state_d     = ST_SEC;
          enter_field = 1'b1;
        end else if (min_pulse) begin
          state_d     = ST_MIN;
          enter_field = 1'b1;
        end else if (hour_pulse) begin
          state_d     = ST_HOUR;
          enter_field = 1'b1;
        end
      end
      default: state_d = ST_DISPLAY;
    endcase

    // Entering (or re-selecting) a field starts in the blanked phase, and that
    // takes precedence over a coincident blink tick.
    if (enter_field) begin
      phase_d = 1'b1;
    end else if (state_d == ST_SEC || state_d == ST_MIN || state_d == ST_HOUR) begin
      if (tick_pulse) phase_d = ~phase_q;
    end else begin
      phase_d = 1'b0;
    end
  end

  // Moore outputs straight from registered state, so reset clears them at once.
  assign blink_sec_day   = (state_q == ST_SEC)  & phase_q;
  assign blink_min_month = (state_q == ST_MIN)  & phase_q;
  assign blink_hour_year = (state_q == ST_HOUR) & phase_q;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic clk;
  logic rst;
  logic display;
  logic blink_tick;
  logic setup_second_day;
  logic setup_minute_month;
  logic setup_hour_year;
  logic blink_sec_day;
  logic blink_min_month;
  logic blink_hour_year;
  logic [2:0] out_v;

  int passed;
  int total;

  control_unit #(.SYNC_STAGES(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .display            (display),
    .blink_tick         (blink_tick),
    .setup_second_day   (setup_second_day),
    .setup_minute_month (setup_minute_month),
    .setup_hour_year    (setup_hour_year),
    .blink_sec_day      (blink_sec_day),
    .blink_min_month    (blink_min_month),
    .blink_hour_year    (blink_hour_year)
  );

  // Bit order: {hour_year, min_month, sec_day}
  assign out_v = {blink_hour_year, blink_min_month, blink_sec_day};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    display = 1'b0;
    blink_tick = 1'b0;
    setup_second_day = 1'b1;
    setup_minute_month = 1'b1;
    setup_hour_year = 1'b1;
    step(2);
    total++;
    if (out_v !== 3'b000) $display("FAIL reset_hold got %b want 000", out_v);
    else passed++;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      total++;
      if (out_v !== 3'b000) $display("FAIL reset_idle cycle %0d got %b want 000", i, out_v);
      else passed++;
    end
  endtask

  task automatic test_enter_sec;
    display = 1'b1; step(1); display = 1'b0; step(2);
    total++;
    if (out_v !== 3'b000) $display("FAIL setup_entry got %b want 000", out_v);
    else passed++;
    setup_second_day = 1'b0; step(2);
    total++;
    if (out_v !== 3'b000) $display("FAIL sec_latency got %b want 000", out_v);
    else passed++;
    step(1);
    total++;
    if (out_v !== 3'b001) $display("FAIL sec_entry got %b want 001", out_v);
    else passed++;
    step(3);
    total++;
    if (out_v !== 3'b001) $display("FAIL sec_hold got %b want 001", out_v);
    else passed++;
    setup_second_day = 1'b1; step(3);
    total++;
    if (out_v !== 3'b001) $display("FAIL sec_release got %b want 001", out_v);
    else passed++;
    blink_tick = 1'b1; step(1); blink_tick = 1'b0; step(2);
    total++;
    if (out_v !== 3'b000) $display("FAIL tick_first got %b want 000", out_v);
    else passed++;
    blink_tick = 1'b1; step(3);
    total++;
    if (out_v !== 3'b001) $display("FAIL tick_second got %b want 001", out_v);
    else passed++;
    blink_tick = 1'b0; step(3);
    total++;
    if (out_v !== 3'b001) $display("FAIL tick_held_once got %b want 001", out_v);
    else passed++;
  endtask

  task automatic test_field_switch;
    setup_minute_month = 1'b0; step(3);
    total++;
    if (out_v !== 3'b010) $display("FAIL sec_to_min got %b want 010", out_v);
    else passed++;
    setup_minute_month = 1'b1; step(3);
    setup_hour_year = 1'b0; step(3);
    total++;
    if (out_v !== 3'b100) $display("FAIL min_to_hour got %b want 100", out_v);
    else passed++;
    setup_hour_year = 1'b1; step(3);
    blink_tick = 1'b1; step(1); blink_tick = 1'b0; step(2);
    total++;
    if (out_v !== 3'b000) $display("FAIL hour_tick got %b want 000", out_v);
    else passed++;
    setup_hour_year = 1'b0; step(3);
    total++;
    if (out_v !== 3'b100) $display("FAIL hour_reselect got %b want 100", out_v);
    else passed++;
    setup_hour_year = 1'b1; step(3);
  endtask

  task automatic test_tick_entry;
    // In SETUP_HOUR with phase 1: a tick alone would clear phase.
    setup_second_day = 1'b0;
    blink_tick = 1'b1; step(1); blink_tick = 1'b0; step(2);
    total++;
    if (out_v !== 3'b001) $display("FAIL entry_beats_tick got %b want 001", out_v);
    else passed++;
    setup_second_day = 1'b1; step(3);
  endtask

  task automatic test_display_exit;
    setup_hour_year = 1'b0; step(3);
    total++;
    if (out_v !== 3'b100) $display("FAIL hour_select got %b want 100", out_v);
    else passed++;
    setup_hour_year = 1'b1; step(3);
    display = 1'b1; step(1); display = 1'b0; step(2);
    total++;
    if (out_v !== 3'b000) $display("FAIL hour_to_display got %b want 000", out_v);
    else passed++;
    blink_tick = 1'b1; step(1); blink_tick = 1'b0; step(2);
    total++;
    if (out_v !== 3'b000) $display("FAIL display_tick got %b want 000", out_v);
    else passed++;
    setup_second_day = 1'b0; step(3);
    total++;
    if (out_v !== 3'b000) $display("FAIL display_ignores_sec got %b want 000", out_v);
    else passed++;
    setup_second_day = 1'b1; step(3);
    setup_minute_month = 1'b0; step(3);
    total++;
    if (out_v !== 3'b000) $display("FAIL display_ignores_min got %b want 000", out_v);
    else passed++;
    setup_minute_month = 1'b1; step(3);
    setup_hour_year = 1'b0; step(3);
    total++;
    if (out_v !== 3'b000) $display("FAIL display_ignores_hour got %b want 000", out_v);
    else passed++;
    setup_hour_year = 1'b1; step(3);
    display = 1'b1; step(1); display = 1'b0; step(2);
    setup_second_day = 1'b0; step(3);
    total++;
    if (out_v !== 3'b001) $display("FAIL resume_sec got %b want 001", out_v);
    else passed++;
    setup_second_day = 1'b1; step(3);
  endtask

  task automatic test_priority;
    // SETUP_SEC -> DISPLAY -> SETUP
    display = 1'b1; step(1); display = 1'b0; step(2);
    display = 1'b1; step(1); display = 1'b0; step(2);
    display = 1'b1; setup_second_day = 1'b0; step(1); display = 1'b0; step(2);
    total++;
    if (out_v !== 3'b000) $display("FAIL disp_over_sec got %b want 000", out_v);
    else passed++;
    setup_second_day = 1'b1; step(3);
    // Still in DISPLAY: a sec press must be ignored.
    setup_second_day = 1'b0; step(3);
    total++;
    if (out_v !== 3'b000) $display("FAIL prio_left_display got %b want 000", out_v);
    else passed++;
    setup_second_day = 1'b1; step(3);
    display = 1'b1; step(1); display = 1'b0; step(2);
    setup_second_day = 1'b0; setup_hour_year = 1'b0; step(3);
    total++;
    if (out_v !== 3'b001) $display("FAIL sec_over_hour got %b want 001", out_v);
    else passed++;
    setup_second_day = 1'b1; setup_hour_year = 1'b1; step(3);
  endtask

  task automatic test_async_reset;
    display = 1'b1; step(1); display = 1'b0; step(2);
    display = 1'b1; step(1); display = 1'b0; step(2);
    setup_minute_month = 1'b0; step(3);
    setup_minute_month = 1'b1; step(3);
    total++;
    if (out_v !== 3'b010) $display("FAIL min_before_reset got %b want 010", out_v);
    else passed++;
    rst = 1'b0;
    #2;
    total++;
    if (out_v !== 3'b000) $display("FAIL async_drop got %b want 000", out_v);
    else passed++;
    step(2);
    rst = 1'b1;
    step(5);
    total++;
    if (out_v !== 3'b000) $display("FAIL post_reset_idle got %b want 000", out_v);
    else passed++;
    setup_second_day = 1'b0; step(3);
    total++;
    if (out_v !== 3'b000) $display("FAIL post_reset_display got %b want 000", out_v);
    else passed++;
    setup_second_day = 1'b1; step(3);
    display = 1'b1; step(1); display = 1'b0; step(2);
    setup_second_day = 1'b0; step(3);
    total++;
    if (out_v !== 3'b001) $display("FAIL post_reset_resume got %b want 001", out_v);
    else passed++;
    setup_second_day = 1'b1; step(3);
  endtask

  initial begin
    passed = 0;
    total = 0;
    test_reset();
    test_enter_sec();
    test_field_switch();
    test_tick_entry();
    test_display_exit();
    test_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Mode/field-select controller for the clock/calendar front panel. Button strobes move it between normal display and field-setup modes. It drives three blink enables that tell the display driver which digit pair (seconds/day, minutes/month, hours/year) is currently being edited. The display blanking logic consumes the blink enables; a slow divider supplies blink_tick.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on every asynchronous input (minimum 2).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous reset, active-low.
display  input  1  mode button, active-high; a press is a 0->1 transition.
blink_tick  input  1  blink timebase, active-high; each 0->1 transition is one blink event; level width is don't-care.
setup_second_day  input  1  field-select button for seconds/day, active-low (idle 1); a press is a 1->0 transition.
setup_minute_month  input  1  field-select button for minutes/month, active-low (idle 1).
setup_hour_year  input  1  field-select button for hours/year, active-low (idle 1).
blink_sec_day  output  1  1 = blank the seconds/day field in the current blink phase.
blink_min_month  output  1  1 = blank the minutes/month field.
blink_hour_year  output  1  1 = blank the hours/year field.

Behaviour:
- Input conditioning
  - All five inputs pass through a SYNC_STAGES-flop synchronizer.
  - Each synchronizer is followed by a one-flop edge detector producing a single-cycle pulse: rising edge for display and blink_tick, falling edge for the setup_* inputs.
  - Holding an input at its active level produces exactly one pulse.
  - Latency with SYNC_STAGES=2: an input change sampled at rising edge k updates the state at edge k+2.
- Reset (rst=0, asynchronous)
  - State = DISPLAY, blink phase = 0, all outputs 0.
  - Synchronizer and edge flops preset to idle levels: display/blink_tick chains 0, setup_* chains 1. No spurious press is therefore detected after reset release, even when inputs idle at 1.
- States: DISPLAY, SETUP, SETUP_SEC, SETUP_MIN, SETUP_HOUR (3-bit encoding; unused codes recover to DISPLAY).
- Transitions, evaluated per clock on the edge pulses. Priority: display > setup_second_day > setup_minute_month > setup_hour_year.
  - DISPLAY: display pulse -> SETUP. setup_* pulses are ignored.
  - SETUP: display pulse -> DISPLAY; sec pulse -> SETUP_SEC; min pulse -> SETUP_MIN; hour pulse -> SETUP_HOUR.
  - SETUP_SEC / SETUP_MIN / SETUP_HOUR: display pulse -> DISPLAY. A setup_* pulse jumps directly to the corresponding SETUP_x state, including re-selecting the current one.
- Blink phase register (1 bit)
  - Set to 1 on every transition into a SETUP_x state, including re-selection.
  - Toggles on each blink_tick pulse while the state is SETUP_x.
  - Cleared to 0 in DISPLAY and SETUP.
  - If a blink_tick pulse and a transition into SETUP_x occur in the same cycle, the entry value 1 wins.
- Outputs (Moore; decoded only from registered state and phase)
  - blink_sec_day = (state==SETUP_SEC) & phase.
  - blink_min_month = (state==SETUP_MIN) & phase.
  - blink_hour_year = (state==SETUP_HOUR) & phase.
  - At most one output is high at any time. All outputs are 0 in DISPLAY and SETUP.
- Reset mid-operation: outputs drop to 0 immediately (asynchronously) and the FSM returns to DISPLAY.

Test Plan:
- Reset with all setup_* held at 1, release rst, idle 10 cycles -> state DISPLAY, all three outputs 0, no transition.
- DISPLAY, pulse display 1 for 1 cycle, then setup_second_day 1->0 -> SETUP, then SETUP_SEC 2 cycles after the falling edge. blink_sec_day=1 immediately after entry. First blink_tick rising edge -> 0, next -> 1. A blink_tick held high for 3 cycles counts as one toggle.
- In SETUP_SEC press setup_minute_month -> blink_sec_day=0 and blink_min_month=1 in the same cycle. Then press setup_hour_year -> only blink_hour_year=1.
- In SETUP_HOUR press display -> DISPLAY, all outputs 0. Further blink_tick and setup_* presses produce no output change until display is pressed again.
- Simultaneous display and setup_second_day presses while in SETUP -> DISPLAY (display priority). Simultaneous sec and hour presses in SETUP -> SETUP_SEC.
- Assert rst while blink_min_month=1 -> output 0 without waiting for a clock. After release the state is DISPLAY and setup inputs idling at 1 cause no selection.
